// File: rtl/qe_sim_controller.sv
// Sequencing controller for the quadrature-encoder simulator: runs the generator
// for a fixed or continuous number of phase steps and tracks a signed position.
module qe_sim_controller #(
  parameter int unsigned PERIOD_W   = 16,
  parameter int unsigned COUNT_W    = 16,
  parameter int unsigned POS_W      = 32,
  parameter int unsigned MIN_PERIOD = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [COUNT_W-1:0]  cfg_count,
  input  logic                cfg_dir,
  input  logic                cmd_start,
  input  logic                cmd_stop,
  input  logic                cmd_clear_pos,
  input  logic                gen_step_done,
  input  logic                gen_idle,
  output logic                gen_enable,
  output logic [PERIOD_W-1:0] gen_period,
  output logic                gen_dir,
  output logic                busy,
  output logic                done,
  output logic                err_cfg,
  output logic [COUNT_W-1:0]  steps_done,
  output logic [POS_W-1:0]    position
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                dir_q, dir_d;
  logic [COUNT_W-1:0]  remaining_q, remaining_d;
  logic                continuous_q, continuous_d;
  logic [COUNT_W-1:0]  steps_q, steps_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                err_q, err_d;
  logic                enable_q, busy_q, done_q;
  logic                count_step;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    dir_d        = dir_q;
    remaining_d  = remaining_q;
    continuous_d = continuous_q;
    steps_d      = steps_q;
    pos_d        = pos_q;
    err_d        = 1'b0;
    count_step   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_clear_pos) begin
          pos_d = '0;
        end
        // stop wins over a simultaneous start
        if (cmd_start && !cmd_stop && gen_idle) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cfg_period < PERIOD_W'(MIN_PERIOD)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        period_d     = cfg_period;
        dir_d        = cfg_dir;
        remaining_d  = cfg_count;
        continuous_d = (cfg_count == '0);
        steps_d      = '0;
        state_d      = S_RUN;
      end
      S_RUN: begin
        if (gen_step_done) begin
          count_step = 1'b1;
          if (!continuous_q) begin
            remaining_d = remaining_q - COUNT_W'(1);
          end
        end
        if (cmd_stop ||
            (gen_step_done && !continuous_q && remaining_q == COUNT_W'(1))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // an in-flight step still lands after enable drops
        count_step = gen_step_done;
        if (gen_idle && !gen_step_done) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (count_step) begin
      steps_d = steps_q + COUNT_W'(1);
      pos_d   = dir_q ? (pos_q - POS_W'(1)) : (pos_q + POS_W'(1));
    end
  end

  // Datapath and registered status outputs, decoded from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_q     <= '0;
      dir_q        <= 1'b0;
      remaining_q  <= '0;
      continuous_q <= 1'b0;
      steps_q      <= '0;
      pos_q        <= '0;
      err_q        <= 1'b0;
      enable_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      period_q     <= period_d;
      dir_q        <= dir_d;
      remaining_q  <= remaining_d;
      continuous_q <= continuous_d;
      steps_q      <= steps_d;
      pos_q        <= pos_d;
      err_q        <= err_d;
      enable_q     <= (state_d == S_RUN);
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
    end
  end

  assign gen_enable = enable_q;
  assign gen_period = period_q;
  assign gen_dir    = dir_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_cfg    = err_q;
  assign steps_done = steps_q;
  assign position   = pos_q;

endmodule

// File: tb/tb_qe_sim_controller.sv
// Scoreboard bench for qe_sim_controller: directed bursts with a second narrow
// build (COUNT_W=4, POS_W=8) sharing the stimulus for wrap behaviour.
module tb_qe_sim_controller;

  logic        clk;
  logic        reset;
  logic [15:0] cfg_period;
  logic [15:0] cfg_count;
  logic        cfg_dir;
  logic        cmd_start;
  logic        cmd_stop;
  logic        cmd_clear_pos;
  logic        gen_step_done;
  logic        gen_idle;

  logic        gen_enable, gen_dir, busy, done, err_cfg;
  logic [15:0] gen_period;
  logic [15:0] steps_done;
  logic [31:0] position;

  logic        s_gen_enable, s_gen_dir, s_busy, s_done, s_err_cfg;
  logic [15:0] s_gen_period;
  logic [3:0]  s_steps_done;
  logic [7:0]  s_position;

  typedef struct {
    logic is_err;
    int   steps;
    int   pos;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  qe_sim_controller u_dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_period    (cfg_period),
    .cfg_count     (cfg_count),
    .cfg_dir       (cfg_dir),
    .cmd_start     (cmd_start),
    .cmd_stop      (cmd_stop),
    .cmd_clear_pos (cmd_clear_pos),
    .gen_step_done (gen_step_done),
    .gen_idle      (gen_idle),
    .gen_enable    (gen_enable),
    .gen_period    (gen_period),
    .gen_dir       (gen_dir),
    .busy          (busy),
    .done          (done),
    .err_cfg       (err_cfg),
    .steps_done    (steps_done),
    .position      (position)
  );

  qe_sim_controller #(.COUNT_W(4), .POS_W(8)) u_small (
    .clk           (clk),
    .reset         (reset),
    .cfg_period    (cfg_period),
    .cfg_count     (cfg_count[3:0]),
    .cfg_dir       (cfg_dir),
    .cmd_start     (cmd_start),
    .cmd_stop      (cmd_stop),
    .cmd_clear_pos (cmd_clear_pos),
    .gen_step_done (gen_step_done),
    .gen_idle      (gen_idle),
    .gen_enable    (s_gen_enable),
    .gen_period    (s_gen_period),
    .gen_dir       (s_gen_dir),
    .busy          (s_busy),
    .done          (s_done),
    .err_cfg       (s_err_cfg),
    .steps_done    (s_steps_done),
    .position      (s_position)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pops one expected record per done/err_cfg pulse
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && (done || err_cfg)) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event done=%0b err_cfg=%0b (t=%0t)", done, err_cfg, $time);
        end else begin
          e = sb_q.pop_front();
          check("event_is_err", longint'(err_cfg), longint'(e.is_err));
          check("event_steps_done", longint'(steps_done), longint'(e.steps));
          check("event_position", longint'(int'(position)), longint'(e.pos));
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic is_err, input int steps, input int pos);
    exp_t e;
    e.is_err = is_err;
    e.steps  = steps;
    e.pos    = pos;
    sb_q.push_back(e);
  endtask

  task automatic start_burst(input int per, input int cnt, input logic dir);
    cfg_period = 16'(per);
    cfg_count  = 16'(cnt);
    cfg_dir    = dir;
    cmd_start  = 1'b1;
    cyc();
    cmd_start = 1'b0;
    check("start_busy_t1", longint'(busy), 1);
    check("start_enable_t1", longint'(gen_enable), 0);
    cyc();
    check("start_enable_t2", longint'(gen_enable), 0);
    cyc();
    check("start_enable_t3", longint'(gen_enable), 1);
    check("start_gen_period", longint'(gen_period), longint'(per));
    check("start_gen_dir", longint'(gen_dir), longint'(dir));
    gen_idle = 1'b0;
  endtask

  task automatic step(input int gap);
    repeat (gap) cyc();
    gen_step_done = 1'b1;
    cyc();
    gen_step_done = 1'b0;
  endtask

  task automatic finish_drain();
    gen_idle = 1'b1;
    cyc();
    cyc();
    cyc();
    check("after_done_busy", longint'(busy), 0);
  endtask

  task automatic stop_now();
    cmd_stop = 1'b1;
    cyc();
    cmd_stop = 1'b0;
    check("stop_enable_low", longint'(gen_enable), 0);
  endtask

  initial begin
    reset = 1'b0;
    cfg_period = '0;
    cfg_count = '0;
    cfg_dir = 1'b0;
    cmd_start = 1'b0;
    cmd_stop = 1'b0;
    cmd_clear_pos = 1'b0;
    gen_step_done = 1'b0;
    gen_idle = 1'b1;
    fork
      monitor();
    join_none

    #22;
    check("reset_enable", longint'(gen_enable), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_position", longint'(position), 0);
    check("reset_steps", longint'(steps_done), 0);
    check("reset_period", longint'(gen_period), 0);
    reset = 1'b1;
    cyc();
    cmd_clear_pos = 1'b1;
    cyc();
    cmd_clear_pos = 1'b0;

    // Fixed forward burst, step every 40 clocks
    push_exp(1'b0, 5, 5);
    start_burst(10, 5, 1'b0);
    for (int i = 0; i < 4; i++) step(39);
    check("fixed_enable_before_last", longint'(gen_enable), 1);
    step(39);
    check("fixed_enable_after_last", longint'(gen_enable), 0);
    check("fixed_steps_direct", longint'(steps_done), 5);
    finish_drain();

    // Reverse continuous, stop after 7, in-flight 8th during drain
    push_exp(1'b0, 8, -3);
    start_burst(10, 0, 1'b1);
    for (int i = 0; i < 7; i++) step(3);
    stop_now();
    check("drain_busy", longint'(busy), 1);
    step(0);
    finish_drain();

    // Illegal period
    push_exp(1'b1, 8, -3);
    cfg_period = 16'd3;
    cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    check("reject_busy_t1", longint'(busy), 1);
    cyc();
    check("reject_busy_t2", longint'(busy), 0);
    check("reject_enable_t2", longint'(gen_enable), 0);
    repeat (3) cyc();
    check("reject_enable_later", longint'(gen_enable), 0);

    // Start and stop together
    cfg_period = 16'd10;
    cmd_start = 1'b1;
    cmd_stop = 1'b1;
    cyc();
    cmd_start = 1'b0;
    cmd_stop = 1'b0;
    check("startstop_busy", longint'(busy), 0);
    repeat (2) cyc();
    check("startstop_enable", longint'(gen_enable), 0);

    // Stop coinciding with the final step
    push_exp(1'b0, 3, 0);
    start_burst(5, 3, 1'b0);
    step(2);
    step(2);
    repeat (2) cyc();
    gen_step_done = 1'b1;
    cmd_stop = 1'b1;
    cyc();
    gen_step_done = 1'b0;
    cmd_stop = 1'b0;
    check("final_stop_enable", longint'(gen_enable), 0);
    finish_drain();

    // Start, clear and cfg change while busy are ignored
    push_exp(1'b0, 2, 2);
    start_burst(8, 2, 1'b0);
    cyc();
    cfg_period = 16'd20;
    cfg_dir = 1'b1;
    cmd_start = 1'b1;
    cmd_clear_pos = 1'b1;
    cyc();
    cmd_start = 1'b0;
    cmd_clear_pos = 1'b0;
    step(2);
    check("busy_gen_period", longint'(gen_period), 8);
    check("busy_gen_dir", longint'(gen_dir), 0);
    check("busy_position", longint'(int'(position)), 1);
    step(2);
    finish_drain();

    // Step pulse in IDLE is ignored; clear in IDLE honoured
    step(0);
    check("idle_step_position", longint'(int'(position)), 2);
    check("idle_step_steps", longint'(steps_done), 2);
    cmd_clear_pos = 1'b1;
    cyc();
    cmd_clear_pos = 1'b0;
    check("clear_position", longint'(position), 0);
    check("clear_small_position", longint'(s_position), 0);

    // Wrap of steps_done in the narrow build
    push_exp(1'b0, 20, 20);
    start_burst(4, 0, 1'b0);
    for (int i = 0; i < 20; i++) step(1);
    stop_now();
    finish_drain();
    check("wrap_small_steps", longint'(s_steps_done), 4);
    check("wrap_small_pos20", longint'(int'($signed(s_position))), 20);

    // Position wrap in the narrow build
    cmd_clear_pos = 1'b1;
    cyc();
    cmd_clear_pos = 1'b0;
    push_exp(1'b0, 130, 130);
    start_burst(4, 0, 1'b0);
    for (int i = 0; i < 130; i++) step(1);
    stop_now();
    finish_drain();
    check("wrap_small_pos130", longint'(int'($signed(s_position))), -126);
    check("wrap_small_steps130", longint'(s_steps_done), 2);

    // Asynchronous reset mid-run
    start_burst(10, 3, 1'b0);
    step(2);
    #3;
    reset = 1'b0;
    #1;
    check("midreset_enable", longint'(gen_enable), 0);
    check("midreset_busy", longint'(busy), 0);
    check("midreset_position", longint'(position), 0);
    check("midreset_steps", longint'(steps_done), 0);
    check("midreset_period", longint'(gen_period), 0);
    check("midreset_small_pos", longint'(s_position), 0);
    #2;
    reset = 1'b1;
    gen_idle = 1'b1;
    cyc();
    check("postreset_busy", longint'(busy), 0);
    check("postreset_enable", longint'(gen_enable), 0);
    repeat (3) cyc();
    check("scoreboard_empty", longint'(sb_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qe_sim_controller.md
# qe_sim_controller

Sequencing controller for the quadrature-encoder simulator generator. It accepts a start/stop command with a phase period, step count and direction. It holds the generator enabled for exactly the requested number of phase steps, or continuously, and tracks a signed simulated position. It sits between the host register interface and the QE generator FSM/datapath, giving test firmware deterministic encoder bursts.

## Interface
Parameters:
- PERIOD_W, 16, width of phase period (clocks per phase step)
- COUNT_W, 16, width of step count and steps_done
- POS_W, 32, width of signed position
- MIN_PERIOD, 4, smallest legal cfg_period

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- cfg_period  in  PERIOD_W  requested clocks per phase step
- cfg_count  in  COUNT_W  phase steps to generate; 0 = continuous
- cfg_dir  in  1  0 = forward (A leads), 1 = reverse
- cmd_start  in  1  one-cycle start request
- cmd_stop  in  1  one-cycle stop request
- cmd_clear_pos  in  1  clear position (honoured only when idle)
- gen_step_done  in  1  one-cycle pulse from generator: one phase step completed
- gen_idle  in  1  generator is in its idle state
- gen_enable  out  1  enable to generator
- gen_period  out  PERIOD_W  latched period to generator phase timer
- gen_dir  out  1  latched direction to generator
- busy  out  1  burst in progress (any state other than IDLE)
- done  out  1  one-cycle pulse when a burst finishes
- err_cfg  out  1  one-cycle pulse when a start is rejected
- steps_done  out  COUNT_W  steps completed in the current/last burst
- position  out  POS_W  signed simulated position, two's complement

## Operation
- Moore FSM with states IDLE, CHECK, LOAD, RUN, DRAIN, DONE.
- IDLE: start accepted only when gen_idle=1. If cmd_start and cmd_stop arrive together, stop wins and nothing starts. cmd_clear_pos zeroes position.
- CHECK: evaluates the start request.
  - cfg_period < MIN_PERIOD: err_cfg pulses, return to IDLE.
  - Otherwise go to LOAD.
- LOAD: latch gen_period, gen_dir, remaining=cfg_count and continuous=(cfg_count==0); clear steps_done. Go to RUN.
- RUN: gen_enable=1.
  - On each gen_step_done: steps_done+1 (wraps modulo 2^COUNT_W); position +1 if gen_dir=0, else -1 (wraps modulo 2^POS_W); remaining-1 unless continuous.
  - gen_step_done with remaining==1 (non-continuous) → DRAIN.
  - cmd_stop → DRAIN. If it coincides with gen_step_done, that step is still counted.
- DRAIN: gen_enable=0. Any further gen_step_done (an in-flight step) is counted. Go to DONE when gen_idle=1 and gen_step_done=0.
- DONE: done=1 for one cycle, then IDLE.
- Ignored inputs:
  - cfg_* changes after LOAD.
  - cmd_start while busy.
  - cmd_clear_pos while busy.
- gen_step_done outside RUN/DRAIN is ignored.

## Timing
- All outputs registered or decoded from the state register; no combinational input-to-output paths.
- Reset values: state IDLE; gen_enable 0, gen_period 0, gen_dir 0, busy 0, done 0, err_cfg 0, steps_done 0, position 0.
- Start latency: cmd_start in cycle t (IDLE, gen_idle=1) → CHECK t+1, LOAD t+2, RUN and gen_enable=1 at t+3. busy=1 from t+1.
- Reject latency: err_cfg=1 in cycle t+2; busy=1 only in t+1.
- Final step: gen_step_done in cycle t with remaining==1 → gen_enable=0 from t+1. The generator therefore never sees enable in the idle state after the final step.
- Stop latency: cmd_stop in cycle t → gen_enable=0 from t+1.
- DRAIN exit: with gen_idle=1 in t+1 → DONE t+2, done pulse t+2, IDLE t+3.
- Counters update on the clock edge ending the gen_step_done cycle.
- Reset asserted mid-burst forces all reset values immediately, including position.

## Test plan
- Reset: assert mid-RUN with gen_enable=1 → all outputs 0 asynchronously, state IDLE after release.
- Fixed burst: period=10, count=5, dir=0, generator model returns step_done every 4×10 clocks → exactly 5 steps; position=+5; steps_done=5; single done pulse; gen_enable low the cycle after the 5th step_done.
- Reverse continuous: count=0, dir=1, position preset by prior run to +5; cmd_stop after 7 steps, with an 8th step_done during DRAIN → steps_done=8, position=-3, done pulses.
- Illegal config: period=3 → err_cfg pulses at t+2, gen_enable never asserts, busy drops at t+2.
- Simultaneous events:
  - start+stop together in IDLE → no start.
  - stop in the same cycle as the final step_done → count=N, one done pulse.
  - cmd_start while busy and a cfg change mid-run → gen_period/gen_dir unchanged.
- Wrap: COUNT_W=4 build, continuous for 20 steps → steps_done=4. POS_W=8 build: clear position, then run 130 forward steps → position=-126.
